// File: rtl/tw_req_arbiter.sv
// Round-robin arbiter merging NUM_PORTS taskwait request streams into one engine stream.
// The grant is locked for a whole PKT_BEATS-beat message so beats never interleave.
module tw_req_arbiter #(
   parameter int  NUM_PORTS = 4,
   parameter int  MAX_ACCS  = 16,
   parameter int  PKT_BEATS = 2,
   localparam int ACC_BITS  = $clog2(MAX_ACCS),
   localparam int GW        = $clog2(NUM_PORTS)
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_PORTS*64-1:0]       in_TDATA,
   input  logic [NUM_PORTS-1:0]          in_TVALID,
   input  logic [NUM_PORTS*ACC_BITS-1:0] in_TID,
   output logic [NUM_PORTS-1:0]          in_TREADY,
   output logic [63:0]                   out_TDATA,
   output logic                          out_TVALID,
   output logic [ACC_BITS-1:0]           out_TID,
   input  logic                          out_TREADY,
   output logic [GW-1:0]                 grant,
   output logic                          busy
);

   localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_FWD  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
   logic [ACC_BITS-1:0] tid_q, tid_d;

   logic [63:0]         data_a [NUM_PORTS];
   logic [ACC_BITS-1:0] tid_a  [NUM_PORTS];
   logic                found;
   logic [GW-1:0]       pick;
   logic                hs;
   int                  idx;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign data_a[p] = in_TDATA[64*p +: 64];
      assign tid_a[p]  = in_TID[ACC_BITS*p +: ACC_BITS];
   end

   // First requester at or after rr_ptr, wrapping modulo NUM_PORTS.
   always_comb begin
      found = 1'b0;
      pick  = grant_q;
      idx   = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && in_TVALID[GW'(idx)]) begin
            found = 1'b1;
            pick  = GW'(idx);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      beat_cnt_d = beat_cnt_q;
      tid_d      = tid_q;
      out_TDATA  = '0;
      out_TVALID = 1'b0;
      in_TREADY  = '0;
      hs         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d    = pick;
               tid_d      = tid_a[pick];
               beat_cnt_d = '0;
               state_d    = S_FWD;
            end
         end
         S_FWD: begin
            out_TDATA          = data_a[grant_q];
            out_TVALID         = in_TVALID[grant_q];
            in_TREADY[grant_q] = out_TREADY;
            hs                 = in_TVALID[grant_q] && out_TREADY;
            if (hs) begin
               if (beat_cnt_q == BW'(PKT_BEATS - 1)) begin
                  beat_cnt_d = '0;
                  state_d    = S_IDLE;
                  rr_ptr_d   = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         tid_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
         tid_q      <= tid_d;
      end
   end

   assign out_TID = tid_q;
   assign grant   = grant_q;
   assign busy    = (state_q == S_FWD);

endmodule

// File: tb/tb_tw_req_arbiter.sv
// Self-checking bench for tw_req_arbiter: vector table, directed corner sequences,
// and randomized traffic against a message-level reference model.
module tb_tw_req_arbiter;

   localparam int NP = 4;
   localparam int PB = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic [NP*64-1:0] in_TDATA;
   logic [NP-1:0] in_TVALID;
   logic [NP*4-1:0] in_TID;
   logic [NP-1:0] in_TREADY;
   logic [63:0]   out_TDATA;
   logic          out_TVALID;
   logic [3:0]    out_TID;
   logic          out_TREADY;
   logic [1:0]    grant;
   logic          busy;

   logic [63:0]   d   [NP];
   logic [3:0]    tid [NP];

   int n_chk  = 0;
   int n_pass = 0;

   tw_req_arbiter #(.NUM_PORTS(NP), .MAX_ACCS(16), .PKT_BEATS(PB)) dut (
      .clk(clk), .rstn(rstn),
      .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TID(in_TID), .in_TREADY(in_TREADY),
      .out_TDATA(out_TDATA), .out_TVALID(out_TVALID), .out_TID(out_TID), .out_TREADY(out_TREADY),
      .grant(grant), .busy(busy)
   );

   for (genvar p = 0; p < NP; p++) begin : g_pack
      assign in_TDATA[64*p +: 64] = d[p];
      assign in_TID[4*p +: 4]     = tid[p];
   end

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] vld;
      logic       rdy;
      logic       ov;
      logic [3:0] tr;
      logic       b;
      logic [1:0] g;
   } vec_t;

   vec_t tbl[$];

   task automatic addv(input logic [3:0] vld, input logic rdy, input logic ov,
                       input logic [3:0] tr, input logic b, input logic [1:0] g);
      vec_t v;
      v.vld = vld; v.rdy = rdy; v.ov = ov; v.tr = tr; v.b = b; v.g = g;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic chk_ctrl(input string tag, input logic ov, input logic [3:0] tr,
                           input logic b, input logic [1:0] g);
      chk({tag, " out_TVALID"}, 64'(out_TVALID), 64'(ov));
      chk({tag, " in_TREADY"},  64'(in_TREADY),  64'(tr));
      chk({tag, " busy"},       64'(busy),       64'(b));
      chk({tag, " grant"},      64'(grant),      64'(g));
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      in_TVALID = '0;
      #2;
      rstn = 1'b1;
      tick();
   endtask

   task automatic set_default_data();
      for (int p = 0; p < NP; p++) d[p] = 64'hC0DE_0000_0000_0000 | 64'(p);
      tid[0] = 4'd7; tid[1] = 4'd9; tid[2] = 4'd5; tid[3] = 4'd12;
   endtask

   // reference model state (message-level)
   int m_owner, m_start, m_sent, m_last;
   logic [3:0] m_tid;

   initial begin
      rstn = 1'b0;
      in_TVALID = '0;
      out_TREADY = 1'b0;
      set_default_data();
      #12;
      rstn = 1'b1;
      #1;
      chk_ctrl("reset", 1'b0, 4'b0000, 1'b0, 2'd0);
      tick();

      // single port 2: header then task id, TID 5
      d[2] = 64'h0000_0001_0000_0000; tid[2] = 4'd5;
      in_TVALID = 4'b0100; out_TREADY = 1'b1;
      #1; chk("A first cycle out_TVALID", 64'(out_TVALID), 64'd0);
      tick();
      tid[2] = 4'd9;
      #1; chk_ctrl("A beat0", 1'b1, 4'b0100, 1'b1, 2'd2);
      chk("A beat0 data", out_TDATA, 64'h0000_0001_0000_0000);
      chk("A beat0 tid", 64'(out_TID), 64'd5);
      tick();
      d[2] = 64'h0000_0000_0000_ABCD;
      #1; chk_ctrl("A beat1", 1'b1, 4'b0100, 1'b1, 2'd2);
      chk("A beat1 data", out_TDATA, 64'h0000_0000_0000_ABCD);
      chk("A beat1 tid", 64'(out_TID), 64'd5);
      tick();
      in_TVALID = '0;
      #1; chk_ctrl("A after", 1'b0, 4'b0000, 1'b0, 2'd2);

      // table: port 2 alone, then all four (from rr=3), then backpressure on port 1
      do_reset();
      set_default_data();
      addv(4'b0100, 1, 0, 4'b0000, 0, 2'd0);
      addv(4'b0100, 1, 1, 4'b0100, 1, 2'd2);
      addv(4'b0100, 1, 1, 4'b0100, 1, 2'd2);
      addv(4'b0000, 1, 0, 4'b0000, 0, 2'd2);
      addv(4'b1111, 1, 0, 4'b0000, 0, 2'd2);
      addv(4'b1111, 1, 1, 4'b1000, 1, 2'd3);
      addv(4'b1111, 1, 1, 4'b1000, 1, 2'd3);
      addv(4'b1111, 1, 0, 4'b0000, 0, 2'd3);
      addv(4'b1111, 1, 1, 4'b0001, 1, 2'd0);
      addv(4'b1111, 1, 1, 4'b0001, 1, 2'd0);
      addv(4'b1111, 1, 0, 4'b0000, 0, 2'd0);
      addv(4'b1111, 1, 1, 4'b0010, 1, 2'd1);
      addv(4'b1111, 1, 1, 4'b0010, 1, 2'd1);
      addv(4'b1111, 1, 0, 4'b0000, 0, 2'd1);
      addv(4'b1111, 1, 1, 4'b0100, 1, 2'd2);
      addv(4'b1111, 1, 1, 4'b0100, 1, 2'd2);
      addv(4'b0000, 1, 0, 4'b0000, 0, 2'd2);
      addv(4'b0010, 1, 0, 4'b0000, 0, 2'd2);
      addv(4'b0010, 1, 1, 4'b0010, 1, 2'd1);
      addv(4'b0010, 0, 1, 4'b0000, 1, 2'd1);
      addv(4'b0010, 0, 1, 4'b0000, 1, 2'd1);
      addv(4'b0010, 1, 1, 4'b0010, 1, 2'd1);
      addv(4'b0000, 1, 0, 4'b0000, 0, 2'd1);
      for (int i = 0; i < tbl.size(); i++) begin
         in_TVALID = tbl[i].vld; out_TREADY = tbl[i].rdy;
         #1;
         chk_ctrl($sformatf("tbl[%0d]", i), tbl[i].ov, tbl[i].tr, tbl[i].b, tbl[i].g);
         if (tbl[i].ov) chk($sformatf("tbl[%0d] data", i), out_TDATA, d[tbl[i].g]);
         if (tbl[i].b)  chk($sformatf("tbl[%0d] tid", i), 64'(out_TID), 64'(tid[tbl[i].g]));
         tick();
      end

      // fairness: port 0 always valid, port 3 joins mid-message
      do_reset();
      in_TVALID = 4'b0001; out_TREADY = 1'b1;
      #1; tick();
      in_TVALID = 4'b1001;
      #1; chk_ctrl("B p0 beat0", 1'b1, 4'b0001, 1'b1, 2'd0);
      tick();
      #1; tick();
      #1; chk_ctrl("B arb", 1'b0, 4'b0000, 1'b0, 2'd0);
      tick();
      #1; chk_ctrl("B p3 beat0", 1'b1, 4'b1000, 1'b1, 2'd3);
      tick();
      #1; chk_ctrl("B p3 beat1", 1'b1, 4'b1000, 1'b1, 2'd3);
      tick();
      #1; tick();
      #1; chk_ctrl("B p0 again", 1'b1, 4'b0001, 1'b1, 2'd0);

      // stalled source holds the grant
      do_reset();
      in_TVALID = 4'b0110; out_TREADY = 1'b1;
      #1; tick();
      #1; chk_ctrl("C beat0", 1'b1, 4'b0010, 1'b1, 2'd1);
      tick();
      for (int i = 0; i < 5; i++) begin
         in_TVALID = 4'b0100;
         #1; chk_ctrl($sformatf("C stall%0d", i), 1'b0, 4'b0010, 1'b1, 2'd1);
         tick();
      end
      in_TVALID = 4'b0110;
      #1; chk_ctrl("C beat1", 1'b1, 4'b0010, 1'b1, 2'd1);
      tick();
      #1; chk_ctrl("C arb", 1'b0, 4'b0000, 1'b0, 2'd1);
      tick();
      #1; chk_ctrl("C p2", 1'b1, 4'b0100, 1'b1, 2'd2);

      // async reset during beat 1
      do_reset();
      in_TVALID = 4'b0010; out_TREADY = 1'b1;
      #1; tick(); #1; tick(); #1; tick();
      in_TVALID = 4'b0100;
      #1; tick(); #1; tick();
      #1; chk_ctrl("D pre-reset", 1'b1, 4'b0100, 1'b1, 2'd2);
      #1; rstn = 1'b0;
      #1; chk_ctrl("D in reset", 1'b0, 4'b0000, 1'b0, 2'd0);
      #2; rstn = 1'b1;
      in_TVALID = 4'b1111;
      #1; chk_ctrl("D released", 1'b0, 4'b0000, 1'b0, 2'd0);
      tick();
      #1; chk_ctrl("D rr from 0", 1'b1, 4'b0001, 1'b1, 2'd0);

      // randomized traffic vs message-level model
      do_reset();
      m_owner = -1; m_start = 0; m_sent = 0; m_last = 0; m_tid = '0;
      for (int c = 0; c < 1500; c++) begin
         logic       e_ov, e_b;
         logic [3:0] e_tr;
         for (int p = 0; p < NP; p++) begin
            in_TVALID[p] = ($urandom_range(0, 9) < 6);
            d[p] = {$urandom, $urandom};
            tid[p] = 4'($urandom);
         end
         out_TREADY = ($urandom_range(0, 9) < 7);
         #1;
         if (m_owner < 0) begin
            e_ov = 1'b0; e_tr = '0; e_b = 1'b0;
         end else begin
            e_ov = in_TVALID[m_owner];
            e_tr = out_TREADY ? (4'b0001 << m_owner) : 4'b0000;
            e_b  = 1'b1;
            m_last = m_owner;
         end
         chk_ctrl($sformatf("R%0d", c), e_ov, e_tr, e_b, 2'(m_last));
         if (m_owner >= 0) begin
            chk($sformatf("R%0d tid", c), 64'(out_TID), 64'(m_tid));
            if (e_ov) chk($sformatf("R%0d data", c), out_TDATA, d[m_owner]);
         end
         if (m_owner < 0) begin
            for (int k = 0; k < NP; k++) begin
               int p;
               p = (m_start + k) % NP;
               if (m_owner < 0 && in_TVALID[p]) begin
                  m_owner = p; m_tid = tid[p]; m_sent = 0; m_last = p;
               end
            end
         end else if (in_TVALID[m_owner] && out_TREADY) begin
            m_sent++;
            if (m_sent == PB) begin
               m_start = (m_owner + 1) % NP;
               m_owner = -1;
            end
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tw_req_arbiter.md
Name: tw_req_arbiter

Overview:
- Round-robin arbiter that merges NUM_PORTS taskwait request streams into the single inStream of the taskwait engine.
- Sources are, for example, accelerator-side taskwait requests and completion notifications from the scheduler.
- Each request is a fixed PKT_BEATS-beat message: header beat, then task-id beat.
- The block locks the grant for the whole message so beats from different sources never interleave. The engine's READ_HEADER/READ_TID sequence depends on this.

Parameters:
- NUM_PORTS, 4, number of requester streams (2..16).
- MAX_ACCS, 16, accelerator count; ACC_BITS = $clog2(MAX_ACCS).
- PKT_BEATS, 2, beats per message (1..4).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_TDATA  in  NUM_PORTS*64  port p data at [64p+63:64p].
- in_TVALID  in  NUM_PORTS  per-port valid.
- in_TID  in  NUM_PORTS*ACC_BITS  per-port source accelerator id.
- in_TREADY  out  NUM_PORTS  per-port ready.
- out_TDATA  out  64  data to the taskwait engine.
- out_TVALID  out  1  valid to the engine.
- out_TID  out  ACC_BITS  accelerator id, latched at the first beat.
- out_TREADY  in  1  engine ready.
- grant  out  $clog2(NUM_PORTS)  currently granted port (debug/status).
- busy  out  1  high while a message is in flight.

Behaviour:
- Reset (async assert, sync-deassert usage):
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant=0, busy=0.
  - out_TVALID=0, in_TREADY=0 on all ports.
  - Reset mid-message abandons the message; the upstream source must also be reset.
- State IDLE:
  - All in_TREADY=0, out_TVALID=0.
  - If any in_TVALID is high: grant ← first port p with in_TVALID[p]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
  - On grant: tid_r ← in_TID[p], beat_cnt ← 0, state ← FWD.
  - Arbitration takes exactly one cycle. Earliest out_TVALID is the cycle after the first in_TVALID is seen.
- State FWD:
  - Combinational passthrough: out_TDATA=in_TDATA[grant], out_TVALID=in_TVALID[grant], in_TREADY[grant]=out_TREADY.
  - Other ports' TREADY=0. out_TID=tid_r for every beat.
  - A handshake is out_TVALID&&out_TREADY. On each handshake beat_cnt increments.
  - On the handshake where beat_cnt==PKT_BEATS-1: state ← IDLE, rr_ptr ← grant+1 (wraps to 0 after NUM_PORTS-1), beat_cnt ← 0.
  - Source deasserting valid mid-message: the grant is held indefinitely; no other port is served.
- busy=(state==FWD).
- grant holds its last value in IDLE.
- Simultaneous requests: served strictly in round-robin order starting at rr_ptr. A port requesting continuously never waits more than NUM_PORTS-1 messages.
- Sustained throughput: PKT_BEATS beats per PKT_BEATS+1 cycles, because of the IDLE arbitration cycle between messages.
- No data is registered in the data path. The only registers are state, rr_ptr, grant, beat_cnt and tid_r.
- in_TID of a non-granted port is ignored. in_TID of the granted port is ignored after beat 0.

Test Plan:
- Single port: port 2 sends header 0x0000_0001_0000_0000 then task id 0xABCD with TID=5, out_TREADY=1. Required: out_TVALID first high 1 cycle after in_TVALID; two beats with out_TID=5; busy high for 2 cycles; grant=2.
- All four ports valid simultaneously from reset (rr_ptr=0), out_TREADY=1. Required: grant order 0,1,2,3. Each message is 2 contiguous beats with no interleaving; 12 cycles total.
- Backpressure: out_TREADY toggles 1,0,0,1 during port 1's message. Required: beats are held stable while ready=0; in_TREADY[1] mirrors out_TREADY; no other in_TREADY goes high.
- Fairness: port 0 always valid, port 3 becomes valid mid-message on port 0. Required: port 3 is served next, then port 0; port 0 is never granted twice in a row while port 3 is waiting.
- Stalled source: port 1 drops in_TVALID after beat 0 for 5 cycles while port 2 is valid. Required: grant stays at 1, port 2 is not served; resumes and completes when port 1 reasserts.
- Async reset asserted during beat 1 of a message. Required: out_TVALID and all in_TREADY go 0 immediately (no clock edge needed). After release, state is IDLE and rr_ptr=0.
